// File: rtl/reg_write_arbiter.sv
// Four-requester write arbiter that owns one shared WIDTH-bit register.
// Define ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (req[0] first).
module reg_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic               ack,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic [7:0]         wr_count,
  output logic [1:0]         dbg_state
);

  // Handshake: a requester holds req[i] high until it sees ack. The write happens on
  // the edge entering LOAD, ack is high during LOAD, and gnt stays high until req[i] drops.
  // Dropping req[i] while in GRANT aborts without writing.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_winner;
  logic             r_ack;
  logic [WIDTH-1:0] r_q;
  logic [7:0]       r_count;

  logic [1:0]       w_base;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_load;
  logic [WIDTH-1:0] w_din_sel;

`ifdef ROUND_ROBIN_EN
  logic [1:0] r_ptr;

  assign w_base = r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 2'd0;
    end else if (w_load) begin
      r_ptr <= r_winner + 2'd1;
    end
  end
`else
  assign w_base = 2'd0;
`endif

  // Walk the offsets from the far end so the request closest to w_base wins.
  always_comb begin
    w_win = 2'd0;
    w_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = w_base + 2'(k);
      if (req[w_idx]) begin
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_din_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_winner == 2'(i)) begin
        w_din_sel = din[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_load = (r_state == ST_GRANT) && req[r_winner];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|req) w_state_nxt = ST_GRANT;
      ST_GRANT:   w_state_nxt = req[r_winner] ? ST_LOAD : ST_IDLE;
      ST_LOAD:    w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (!req[r_winner]) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt    <= 4'b0000;
      r_winner <= 2'd0;
      r_ack    <= 1'b0;
      r_q      <= '0;
      r_count  <= 8'd0;
    end else begin
      r_ack <= w_load;
      if (w_load) begin
        r_q     <= w_din_sel;
        r_count <= r_count + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt    <= 4'b0001 << w_win;
            r_winner <= w_win;
          end
        end
        ST_GRANT:   if (!req[r_winner]) r_gnt <= 4'b0000;
        ST_RELEASE: if (!req[r_winner]) r_gnt <= 4'b0000;
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign q         = r_q;
  assign busy      = (r_state != ST_IDLE);
  assign wr_count  = r_count;
  assign dbg_state = r_state;

endmodule
